// File: rtl/mac_requant.sv
// rtl/mac_requant.sv - int8 requantization stage: bias, fixed-point scale, rounding shift, zero-point, saturate
module mac_requant #(
    parameter int ACC_W   = 32,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 5,
    parameter int OUT_W   = 8,
    parameter int VEC_LEN = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      clr_i,
    input  logic signed [ACC_W-1:0]   cfg_bias_i,
    input  logic        [MULT_W-1:0]  cfg_mult_i,
    input  logic        [SHIFT_W-1:0] cfg_shift_i,
    input  logic signed [OUT_W-1:0]   cfg_zp_i,
    input  logic                      acc_valid_i,
    input  logic signed [ACC_W-1:0]   acc_i,
    output logic                      acc_ready_o,
    output logic                      q_valid_o,
    output logic signed [OUT_W-1:0]   q_data_o,
    output logic                      q_last_o,
    input  logic                      q_ready_i,
    output logic                      busy_o,
    output logic        [15:0]        sat_cnt_o
);

    localparam int SUM_W  = ACC_W + 1;
    localparam int PROD_W = ACC_W + MULT_W + 2;
    localparam int RND_W  = PROD_W + 1;
    localparam int V_W    = RND_W + 1;
    localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(VEC_LEN - 1);
    localparam logic signed [V_W-1:0] Q_MAX    = V_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [V_W-1:0] Q_MIN    = -V_W'(2 ** (OUT_W - 1));

    logic                     r_s1_vld;
    logic signed [SUM_W-1:0]  r_s1_sum;
    logic                     r_s2_vld;
    logic signed [PROD_W-1:0] r_s2_prod;
    logic                     r_q_valid;
    logic signed [OUT_W-1:0]  r_q_data;
    logic        [CNT_W-1:0]  r_cnt;
    logic        [15:0]       r_sat_cnt;

    logic                     w_advance;
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [PROD_W-1:0] w_prod;
    logic        [RND_W-1:0]  w_half;
    logic signed [RND_W-1:0]  w_rnd;
    logic signed [RND_W-1:0]  w_r;
    logic signed [V_W-1:0]    w_v;
    logic                     w_sat_hi;
    logic                     w_sat_lo;
    logic signed [OUT_W-1:0]  w_q;

    assign w_advance = !r_q_valid || q_ready_i;

    assign w_sum  = SUM_W'(acc_i) + SUM_W'(cfg_bias_i);
    // Multiplier is zero-extended so the scale can never flip the sign.
    assign w_prod = PROD_W'(r_s1_sum) * PROD_W'({1'b0, cfg_mult_i});

    assign w_half = (cfg_shift_i == '0) ? '0 : (RND_W'(1) << (cfg_shift_i - SHIFT_W'(1)));
    assign w_rnd  = RND_W'(r_s2_prod) + w_half;
    assign w_r    = w_rnd >>> cfg_shift_i;
    assign w_v    = V_W'(w_r) + V_W'(cfg_zp_i);

    assign w_sat_hi = (w_v > Q_MAX);
    assign w_sat_lo = (w_v < Q_MIN);
    assign w_q      = w_sat_hi ? Q_MAX[OUT_W-1:0] :
                      w_sat_lo ? Q_MIN[OUT_W-1:0] : w_v[OUT_W-1:0];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_s1_vld  <= 1'b0;
            r_s1_sum  <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_prod <= '0;
            r_q_valid <= 1'b0;
            r_q_data  <= '0;
            r_cnt     <= '0;
            r_sat_cnt <= '0;
        end else if (clr_i) begin
            r_s1_vld  <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_q_valid <= 1'b0;
            r_cnt     <= '0;
            r_sat_cnt <= '0;
        end else begin
            if (w_advance) begin
                r_s1_vld  <= acc_valid_i;
                r_s2_vld  <= r_s1_vld;
                r_q_valid <= r_s2_vld;
                if (acc_valid_i) begin
                    r_s1_sum <= w_sum;
                end
                if (r_s1_vld) begin
                    r_s2_prod <= w_prod;
                end
                if (r_s2_vld) begin
                    r_q_data <= w_q;
                    if ((w_sat_hi || w_sat_lo) && (r_sat_cnt != 16'hFFFF)) begin
                        r_sat_cnt <= r_sat_cnt + 16'd1;
                    end
                end
            end
            if (r_q_valid && q_ready_i) begin
                r_cnt <= (r_cnt == LAST_IDX) ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end

    assign acc_ready_o = w_advance;
    assign q_valid_o   = r_q_valid;
    assign q_data_o    = r_q_data;
    assign q_last_o    = r_q_valid && (r_cnt == LAST_IDX);
    assign busy_o      = r_s1_vld || r_s2_vld || r_q_valid;
    assign sat_cnt_o   = r_sat_cnt;

endmodule

// File: tb/tb_mac_requant.sv
// tb/tb_mac_requant.sv - self-checking bench for mac_requant
module tb_mac_requant;

    localparam int VL = 4;

    logic               clk_i = 1'b0;
    logic               rstn_i = 1'b0;
    logic               clr_i = 1'b0;
    logic signed [31:0] cfg_bias_i = '0;
    logic        [15:0] cfg_mult_i = 16'd1;
    logic        [4:0]  cfg_shift_i = '0;
    logic signed [7:0]  cfg_zp_i = '0;
    logic               acc_valid_i = 1'b0;
    logic signed [31:0] acc_i = '0;
    logic               acc_ready_o;
    logic               q_valid_o;
    logic signed [7:0]  q_data_o;
    logic               q_last_o;
    logic               q_ready_i = 1'b1;
    logic               busy_o;
    logic        [15:0] sat_cnt_o;

    mac_requant #(.ACC_W(32), .MULT_W(16), .SHIFT_W(5), .OUT_W(8), .VEC_LEN(VL)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .clr_i(clr_i),
        .cfg_bias_i(cfg_bias_i), .cfg_mult_i(cfg_mult_i), .cfg_shift_i(cfg_shift_i), .cfg_zp_i(cfg_zp_i),
        .acc_valid_i(acc_valid_i), .acc_i(acc_i), .acc_ready_o(acc_ready_o),
        .q_valid_o(q_valid_o), .q_data_o(q_data_o), .q_last_o(q_last_o), .q_ready_i(q_ready_i),
        .busy_o(busy_o), .sat_cnt_o(sat_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int tx_cnt = 0;
    int exp_sat = 0;

    typedef struct {
        logic signed [31:0] acc;
        logic signed [31:0] bias;
        logic        [15:0] mult;
        logic        [4:0]  shift;
        logic signed [7:0]  zp;
        logic signed [7:0]  exp;
        bit                 sat;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Reference: exact integer arithmetic, floor after adding half, then clamp.
    function automatic longint ref_q(input longint acc, input longint bias, input longint mult,
                                     input int shift, input longint zp, output bit sat);
        longint s, p, r, v;
        s = acc + bias;
        p = s * mult;
        r = (shift == 0) ? p : ((p + (longint'(1) << (shift - 1))) >>> shift);
        v = r + zp;
        sat = (v > 127) || (v < -128);
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    task automatic do_clear();
        @(negedge clk_i);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        tx_cnt = 0;
        exp_sat = 0;
    endtask

    task automatic set_cfg(input logic signed [31:0] b, input logic [15:0] m, input logic [4:0] s,
                           input logic signed [7:0] z);
        cfg_bias_i = b; cfg_mult_i = m; cfg_shift_i = s; cfg_zp_i = z;
    endtask

    task automatic run_stream(input int n, input int vpct, input int rpct);
        longint exp_q[$];
        longint e;
        bit     s;
        int     acc_n = 0;
        int     out_n = 0;
        int     cyc = 0;
        while ((acc_n < n || out_n < n) && cyc < 3000) begin
            @(negedge clk_i);
            cyc++;
            q_ready_i = ($urandom_range(99) < rpct);
            #1;
            if (q_valid_o && q_ready_i) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
                check("stream_data", q_data_o, e);
                check("stream_last", q_last_o, (tx_cnt % VL) == VL - 1);
                tx_cnt++;
                out_n++;
            end
            if (acc_n < n && $urandom_range(99) < vpct) begin
                acc_valid_i = 1'b1;
                case ($urandom_range(2))
                    0: acc_i = $signed(32'($urandom_range(400))) - 200;
                    1: acc_i = $signed($urandom);
                    default: acc_i = $signed(32'($urandom_range(2097151))) - 1048576;
                endcase
            end else begin
                acc_valid_i = 1'b0;
            end
            if (acc_valid_i && acc_ready_o) begin
                exp_q.push_back(ref_q(acc_i, cfg_bias_i, cfg_mult_i, cfg_shift_i, cfg_zp_i, s));
                if (s) exp_sat++;
                acc_n++;
            end
        end
        if (cyc >= 3000) timeout("stream");
        @(negedge clk_i);
        acc_valid_i = 1'b0;
        q_ready_i = 1'b1;
        @(negedge clk_i);
        check("stream_sat_cnt", sat_cnt_o, exp_sat);
    endtask

    initial begin
        int n;
        int got[$];
        int stall_left;
        bit stall_started;
        int lasts;
        int tbl_sat;

        tbl.push_back('{acc: 100,   bias: 0,   mult: 1,     shift: 0,  zp: 0,  exp: 100,  sat: 0});
        tbl.push_back('{acc: 3,     bias: 0,   mult: 1,     shift: 1,  zp: 0,  exp: 2,    sat: 0});
        tbl.push_back('{acc: -3,    bias: 0,   mult: 1,     shift: 1,  zp: 0,  exp: -1,   sat: 0});
        tbl.push_back('{acc: 5,     bias: 0,   mult: 1,     shift: 1,  zp: 0,  exp: 3,    sat: 0});
        tbl.push_back('{acc: 5,     bias: 0,   mult: 3,     shift: 2,  zp: 0,  exp: 4,    sat: 0});
        tbl.push_back('{acc: 1000,  bias: 0,   mult: 1,     shift: 0,  zp: 0,  exp: 127,  sat: 1});
        tbl.push_back('{acc: -1000, bias: 0,   mult: 1,     shift: 0,  zp: 0,  exp: -128, sat: 1});
        tbl.push_back('{acc: 30,    bias: -20, mult: 1,     shift: 0,  zp: -5, exp: 5,    sat: 0});
        tbl.push_back('{acc: -1,    bias: 0,   mult: 1,     shift: 31, zp: 0,  exp: 0,    sat: 0});
        tbl.push_back('{acc: 32'sh80000000, bias: 32'sh80000000, mult: 16'hFFFF, shift: 31, zp: 0, exp: -128, sat: 1});
        tbl.push_back('{acc: 254,   bias: 0,   mult: 1,     shift: 1,  zp: 0,  exp: 127,  sat: 0});

        // Reset state
        #1;
        check("rst_q_valid", q_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_sat_cnt", sat_cnt_o, 0);
        check("rst_q_data", q_data_o, 0);
        check("rst_acc_ready", acc_ready_o, 1);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Single-beat vectors: value and 3-cycle latency
        tbl_sat = 0;
        foreach (tbl[i]) begin
            @(negedge clk_i);
            set_cfg(tbl[i].bias, tbl[i].mult, tbl[i].shift, tbl[i].zp);
            acc_valid_i = 1'b1;
            acc_i = tbl[i].acc;
            q_ready_i = 1'b1;
            if (tbl[i].sat) tbl_sat++;
            n = 0;
            do begin
                @(negedge clk_i);
                acc_valid_i = 1'b0;
                n++;
            end while (!q_valid_o && n < 10);
            check($sformatf("tbl%0d_latency", i), n, 3);
            check($sformatf("tbl%0d_data", i), q_data_o, tbl[i].exp);
        end
        @(negedge clk_i);
        check("tbl_sat_cnt", sat_cnt_o, tbl_sat);

        // Back-pressure: 1..6 back-to-back, 4-cycle stall at first output
        do_clear();
        set_cfg(0, 1, 0, 0);
        n = 1;
        stall_started = 0;
        stall_left = 0;
        got.delete();
        for (int cyc = 0; cyc < 60 && got.size() < 6; cyc++) begin
            @(negedge clk_i);
            if (q_valid_o && !stall_started) begin
                stall_started = 1;
                stall_left = 4;
            end
            q_ready_i = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            #1;
            if (q_valid_o && !q_ready_i) check("bp_acc_ready_stalled", acc_ready_o, 0);
            if (q_valid_o && q_ready_i) got.push_back(int'(q_data_o));
            acc_valid_i = (n <= 6);
            acc_i = n;
            if (acc_valid_i && acc_ready_o) n++;
        end
        acc_valid_i = 1'b0;
        q_ready_i = 1'b1;
        check("bp_count", got.size(), 6);
        foreach (got[i]) check($sformatf("bp_out%0d", i), got[i], i + 1);
        @(negedge clk_i);
        @(negedge clk_i);
        check("bp_drained", busy_o, 0);

        // Last flag: 9 beats then 3 more, random ready
        do_clear();
        set_cfg(0, 1, 0, 0);
        run_stream(9, 80, 50);
        check("last_tx9", tx_cnt, 9);
        run_stream(3, 100, 50);

        // Random configurations against the reference
        for (int b = 0; b < 5; b++) begin
            set_cfg($urandom_range(1) ? $signed($urandom) : $signed(32'($urandom_range(2000))) - 1000,
                    16'($urandom), 5'($urandom_range(31)), 8'($urandom));
            run_stream(25, 70, 70);
        end

        // Clear mid-stream
        set_cfg(0, 1, 0, 0);
        q_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            acc_valid_i = 1'b1;
            acc_i = 1000;
        end
        @(negedge clk_i);
        check("clr_pre_busy", busy_o, 1);
        clr_i = 1'b1;
        acc_i = 7;
        @(negedge clk_i);
        clr_i = 1'b0;
        acc_valid_i = 1'b0;
        check("clr_busy", busy_o, 0);
        check("clr_q_valid", q_valid_o, 0);
        check("clr_sat_cnt", sat_cnt_o, 0);
        check("clr_q_last", q_last_o, 0);
        @(negedge clk_i);
        check("clr_dropped_beat", busy_o, 0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            acc_valid_i = 1'b1;
            acc_i = 1000;
        end
        @(negedge clk_i);
        acc_valid_i = 1'b0;
        check("rst_pre_data", q_data_o, 127);
        #2;
        rstn_i = 1'b0;
        #1;
        check("arst_q_valid", q_valid_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_sat_cnt", sat_cnt_o, 0);
        check("arst_q_data", q_data_o, 0);
        check("arst_q_last", q_last_o, 0);
        check("arst_acc_ready", acc_ready_o, 1);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        check("arst_after_busy", busy_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_requant.md
Name: mac_requant

Overview:
- Downstream stage of the int8 DSP MAC. Consumes one signed 32-bit accumulated dot-product per valid beat.
- Per beat it adds a bias, applies a fixed-point scale (multiply, then rounding right shift), adds an output zero-point, and saturates to int8.
- Presents the int8 result on a valid/ready stream to the activation buffer. Flags the last element of each vector and counts saturation events.

Parameters:
- ACC_W, 32, accumulator input width (signed)
- MULT_W, 16, scale multiplier width (unsigned)
- SHIFT_W, 5, right-shift amount width (0..2^SHIFT_W-1)
- OUT_W, 8, output width (signed)
- VEC_LEN, 16, output beats per vector; q_last_o marks beat VEC_LEN (≥1)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- clr_i  in  1  synchronous clear of pipeline, beat counter and sat_cnt_o
- cfg_bias_i  in  ACC_W  signed bias added to the accumulator
- cfg_mult_i  in  MULT_W  unsigned scale multiplier
- cfg_shift_i  in  SHIFT_W  rounding right-shift amount
- cfg_zp_i  in  OUT_W  signed output zero-point
- acc_valid_i  in  1  accumulator beat valid
- acc_i  in  ACC_W  signed accumulator value
- acc_ready_o  out  1  block can accept a beat this cycle
- q_valid_o  out  1  output beat valid
- q_data_o  out  OUT_W  signed quantized result
- q_last_o  out  1  current output beat is element VEC_LEN of the vector
- q_ready_i  in  1  downstream accepts the output beat
- busy_o  out  1  any pipeline stage holds valid data
- sat_cnt_o  out  16  number of saturated results; sticks at 0xFFFF

Behaviour:
- Reset (rstn_i low, asynchronous): all stage valids 0, q_valid_o=0, q_data_o=0, q_last_o=0, sat_cnt_o=0, beat counter=0, busy_o=0. acc_ready_o=1 after reset.
- Pipeline: three registered stages, S1 → S2 → S3. S3 is the output register.
  - S1: sum = acc_i + cfg_bias_i, 33-bit signed, no overflow possible.
  - S2: prod = sum × {0, cfg_mult_i}, 50-bit signed. The multiplier is zero-extended, so scale is always ≥ 0.
  - S3, rounding:
    - if shift = 0, r = prod
    - otherwise r = (prod + 2^(shift-1)) >>> shift, computed at 51-bit width
    - ties therefore round toward +infinity
  - S3, output: v = r + cfg_zp_i. Saturate v to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and store it in q_data_o.
- Stall: advance = !q_valid_o || q_ready_i. acc_ready_o = advance.
  - When advance=1, all stages shift by one.
  - When advance=0, all stages hold and no beat is accepted or lost.
- A beat is accepted only when acc_valid_i && acc_ready_o.
- Latency: 3 cycles from acceptance to q_valid_o, with no back-pressure. Throughput is 1 beat per cycle.
- Bubbles: a stage valid is 0 when the stage before it was empty. Bubbles propagate and never produce output.
- Config: cfg_* are read combinationally in the stage that uses them. They must be held stable while busy_o=1; a change during busy gives undefined per-beat results but no protocol violation.
- Saturation count: sat_cnt_o increments by 1 when a saturated result is loaded into S3, and sticks at 0xFFFF.
- Last flag: the beat counter advances on each output transfer (q_valid_o && q_ready_i).
  - q_last_o = q_valid_o && (counter == VEC_LEN-1).
  - On transfer of the last beat, the counter wraps to 0.
- busy_o = OR of S1, S2 and S3 valids.
- clr_i: next cycle, all valids are 0, the counter is 0 and sat_cnt_o is 0. Any input beat offered in the same cycle is dropped. clr_i wins over a simultaneous transfer or saturation.
- Reset mid-stream: in-flight beats are discarded, and outputs return to their reset values immediately.

Test Plan:
- Pass-through: bias=0, mult=1, shift=0, zp=0; acc_i=100, q_ready_i=1 → q_valid_o=1 with q_data_o=100 exactly 3 cycles after acceptance; sat_cnt_o=0.
- Rounding: mult=1, shift=1; acc_i=3, then -3, then 5 → q_data_o=2, -1, 3. With mult=3, shift=2, acc_i=5 → (15+2)>>>2 = 4.
- Saturation, bias and zero-point:
  - shift=0, acc_i=1000, then -1000 → 127, then -128; sat_cnt_o=2.
  - bias=-20, zp=-5, acc_i=30 → 5.
- Back-pressure: stream 1..6 back-to-back; hold q_ready_i=0 for 4 cycles starting when the first output appears → acc_ready_o=0 while stalled; outputs are exactly 1..6 in order, with no duplicates and no drops.
- Last flag: VEC_LEN=4; 9 beats with random q_ready_i → q_last_o asserted on transfers 4 and 8 only; after the 9th transfer the counter is 1.
- Clear and reset mid-stream: 3 beats in flight, then assert clr_i → next cycle busy_o=0, q_valid_o=0, sat_cnt_o=0. Repeat with rstn_i pulsed low asynchronously → outputs are at reset values before the next clock edge.
